fetch_stage: RTL
================

Name: fetch_stage

Overview:
- First pipeline stage. Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Registers each fetched instruction and its PC for the decode stage, which sits directly downstream.
- Honours STALL and JUMP requests sent backwards from decode. A one-entry buffer absorbs responses that arrive while decode is stalled.

Parameters:
- RESET_ADDRESS, 32'h0000_0000, PC value after reset.
- NOP_INSTRUCTION, 32'h0000_0013, instruction emitted on bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_out  out  1  read request to instruction memory.
- imem_addr_out  out  32  word-aligned read address; stable while imem_req_out=1 and no ack.
- imem_ack_in  in  1  response valid this cycle; only meaningful while imem_req_out=1.
- imem_rdata_in  in  32  instruction word; valid with imem_ack_in.
- instruction_reg_out  out  32  registered instruction to decode.
- program_counter_reg_out  out  32  registered PC of instruction_reg_out.
- status_forwards_out  out  pipeline_status::forwards_t  VALID when the output registers carry a real instruction, else BUBBLE.
- status_backwards_in  in  pipeline_status::backwards_t  from decode: READY, STALL or JUMP.
- jump_address_backwards_in  in  32  redirect target; meaningful when status is JUMP.

Behaviour:
- Reset (rst=0, async):
  - pc = RESET_ADDRESS; instruction_reg_out = NOP_INSTRUCTION; program_counter_reg_out = 0.
  - status_forwards_out = BUBBLE; imem_req_out = 0.
  - Buffer empty; state = FETCH.
- Reset mid-transaction abandons the outstanding request. No drop tracking survives reset.
- imem_addr_out = pc at all times. A request is accepted on a clock edge where imem_req_out=1 and imem_ack_in=1. Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle.
- States:
  - FETCH:
    - imem_req_out=1 unless the buffer is full.
    - On ack with READY: output regs <= {imem_rdata_in, pc}, VALID, pc <= pc+4.
    - On ack with STALL: the response goes into the buffer with its pc, pc <= pc+4, output regs hold. The buffer is now full, so req drops.
    - No ack with READY: status_forwards_out <= BUBBLE and instruction_reg_out <= NOP; program_counter_reg_out holds.
    - No ack with STALL: all output regs hold.
  - DROP:
    - Entered on JUMP while a request is outstanding, i.e. req=1, no ack, and the request was issued in an earlier cycle.
    - req stays 1 at the old address (handshake rule).
    - The response is discarded on ack. Then pc <= the latched jump target and the state returns to FETCH.
    - Output is BUBBLE throughout.
- Buffer drain: when the buffer is full and status is READY, output regs <= buffer contents with VALID. The buffer empties and req resumes the same cycle.
- STALL with output VALID: output regs hold exactly. No instruction is lost or duplicated.
- JUMP has highest priority and is honoured in any state, including during STALL and with the buffer full. On JUMP:
  - Output regs <= NOP, BUBBLE.
  - Buffer cleared.
  - Target latched with bits[1:0] forced to 0.
  - If an ack arrives in the same cycle, that data is discarded and pc <= target, state FETCH.
  - Else if a request is outstanding, go to DROP.
  - Else pc <= target directly.
- JUMP while in DROP replaces the latched target and the state stays DROP.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Latency: an instruction acked at edge N appears on the outputs after edge N, unless it was buffered.

Test Plan:
- Reset release, zero-wait memory returning addr^32'hA5A5_0000:
  - Cycle after reset: imem_addr_out=0, req=1.
  - Outputs then step through PCs 0,4,8 with VALID on consecutive cycles.
- 3-cycle memory latency:
  - Outputs show BUBBLE/NOP for 2 cycles, then VALID.
  - imem_addr_out is stable during the wait.
- STALL asserted while PC 8 is VALID and PC 12 is acked in the same cycle:
  - Outputs hold PC 8; PC 12 is buffered; req=0.
  - On READY, PC 12 appears VALID with no duplication; next fetch is from 16.
- JUMP to 32'h0000_0102 while a request to 16 is outstanding:
  - State DROP; outputs BUBBLE; the ack data for 16 never appears.
  - Next request address is 32'h0000_0100.
- JUMP in the same cycle as an ack, with the buffer full and STALL previously active:
  - Buffer flushed; outputs NOP/BUBBLE; next address = the jump target.
- pc=32'hFFFF_FFFC with zero-wait memory:
  - Next imem_addr_out = 0.
  - Then assert rst mid-request: outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake, and presents registered {instruction, pc} to decode.
// A one-entry skid buffer holds a response that lands while decode stalls.

package pipeline_status;
    typedef enum logic {BUBBLE = 1'b0, VALID = 1'b1} forwards_t;
    typedef enum logic [1:0] {READY = 2'b00, STALL = 2'b01, JUMP = 2'b10} backwards_t;
endpackage

// state | meaning
// FETCH | normal fetching; req follows buffer occupancy and decode readiness
// DROP  | jump taken while a request was in flight; wait for its ack, discard it
module fetch_stage
    import pipeline_status::*;
#(
    parameter logic [31:0] RESET_ADDRESS   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instruction_reg_out,
    output logic [31:0] program_counter_reg_out,
    output forwards_t   status_forwards_out,
    input  backwards_t  status_backwards_in,
    input  logic [31:0] jump_address_backwards_in
);

    typedef enum logic {FETCH = 1'b0, DROP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    forwards_t   valid_q, valid_d;
    logic        buf_full_q, buf_full_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] target_q, target_d;
    logic        pending_q, pending_d;   // current request was already driven last cycle
    logic        started_q;              // keeps req low until the first edge after reset

    logic is_ready, is_jump, req, ack;

    assign is_ready = (status_backwards_in == READY);
    assign is_jump  = (status_backwards_in == JUMP);

    // While the buffer is full, a READY cycle drains it and frees room for a new
    // response in the same cycle, so req only drops when full and not draining.
    assign req = started_q && ((state_q == DROP) || !buf_full_q || is_ready);
    assign ack = req && imem_ack_in;

    assign imem_req_out            = req;
    assign imem_addr_out           = pc_q;
    assign instruction_reg_out     = instr_q;
    assign program_counter_reg_out = pcout_q;
    assign status_forwards_out     = valid_q;

    // Next-state and datapath selection; JUMP takes priority over everything.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pcout_d     = pcout_q;
        valid_d     = valid_q;
        buf_full_d  = buf_full_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        target_d    = target_q;
        pending_d   = 1'b0;

        if (is_jump) begin
            instr_d    = NOP_INSTRUCTION;
            valid_d    = BUBBLE;
            buf_full_d = 1'b0;
            target_d   = jump_address_backwards_in & ~32'd3;
            if (ack) begin
                pc_d    = target_d;
                state_d = FETCH;
            end else if (req && pending_q) begin
                // The memory has seen this address already; the handshake must complete.
                state_d   = DROP;
                pending_d = 1'b1;
            end else begin
                pc_d    = target_d;
                state_d = FETCH;
            end
        end else if (state_q == DROP) begin
            instr_d = NOP_INSTRUCTION;
            valid_d = BUBBLE;
            if (ack) begin
                pc_d    = target_q;
                state_d = FETCH;
            end else begin
                pending_d = 1'b1;
            end
        end else if (buf_full_q) begin
            if (is_ready) begin
                instr_d = buf_instr_q;
                pcout_d = buf_pc_q;
                valid_d = VALID;
                if (ack) begin
                    buf_instr_d = imem_rdata_in;
                    buf_pc_d    = pc_q;
                    pc_d        = pc_q + 32'd4;
                end else begin
                    buf_full_d = 1'b0;
                    pending_d  = req;
                end
            end
        end else if (ack) begin
            if (is_ready) begin
                instr_d = imem_rdata_in;
                pcout_d = pc_q;
                valid_d = VALID;
            end else begin
                buf_instr_d = imem_rdata_in;
                buf_pc_d    = pc_q;
                buf_full_d  = 1'b1;
            end
            pc_d = pc_q + 32'd4;
        end else begin
            pending_d = req;
            if (is_ready) begin
                instr_d = NOP_INSTRUCTION;
                valid_d = BUBBLE;
            end
        end
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_ADDRESS;
            instr_q     <= NOP_INSTRUCTION;
            pcout_q     <= 32'd0;
            valid_q     <= BUBBLE;
            buf_full_q  <= 1'b0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            target_q    <= 32'd0;
            pending_q   <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pcout_q     <= pcout_d;
            valid_q     <= valid_d;
            buf_full_q  <= buf_full_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            started_q   <= 1'b1;
        end
    end

endmodule
